// File: rtl/reg_seq_pkg.sv
// reg_seq_pkg: shared state encoding, command layout and default widths for reg_access_sequencer.
package reg_seq_pkg;
    localparam int DEF_DATA_W = 8;
    localparam int DEF_ADDR_W = 3;
    typedef enum logic [2:0] {IDLE, SETUP, STROBE, CAPTURE, RESP, VSETUP, VSTROBE} state_e;
    typedef struct packed {
        logic                  rw;
        logic [DEF_ADDR_W-1:0] addr;
        logic [DEF_DATA_W-1:0] wdata;
    } cmd_t;
endpackage

// File: rtl/reg_cmd_fifo.sv
// reg_cmd_fifo: synchronous FIFO; DEPTH must be a power of two so pointers wrap naturally.
module reg_cmd_fifo #(
    parameter int WIDTH = 12,
    parameter int DEPTH = 4
) (
    input  logic             Clk,
    input  logic             nReset,
    input  logic             push_i,
    input  logic             pop_i,
    input  logic [WIDTH-1:0] wdata_i,
    output logic [WIDTH-1:0] rdata_o,
    output logic             full_o,
    output logic             empty_o
);
    localparam int PW = $clog2(DEPTH);
    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [PW-1:0] wptr_q, rptr_q;
    logic [PW:0] count_q;
    logic do_push, do_pop;
    assign do_push = push_i && !full_o;
    assign do_pop  = pop_i && !empty_o;
    assign full_o  = count_q[PW];
    assign empty_o = count_q == '0;
    assign rdata_o = mem_q[rptr_q];
    always_ff @(posedge Clk) begin
        if (do_push) mem_q[wptr_q] <= wdata_i;
    end
    always_ff @(posedge Clk) begin
        if (!nReset) begin
            wptr_q  <= '0;
            rptr_q  <= '0;
            count_q <= '0;
        end else begin
            wptr_q  <= wptr_q + PW'(do_push);
            rptr_q  <= rptr_q + PW'(do_pop);
            count_q <= count_q + (PW+1)'(do_push) - (PW+1)'(do_pop);
        end
    end
endmodule

// File: rtl/reg_access_sequencer.sv
// reg_access_sequencer: buffers host commands and runs each through a SETUP/STROBE/CAPTURE access of the register set.
// READBACK_VERIFY_EN adds a read-back of every write and reports mismatches on rsp_err.
module reg_access_sequencer
    import reg_seq_pkg::*;
#(
    parameter int DATA_W     = DEF_DATA_W,
    parameter int ADDR_W     = DEF_ADDR_W,
    parameter int FIFO_DEPTH = 4
) (
    input  logic              Clk,
    input  logic              nReset,
    input  logic              cmd_valid,
    output logic              cmd_ready,
    input  logic              cmd_rw,
    input  logic [ADDR_W-1:0] cmd_addr,
    input  logic [DATA_W-1:0] cmd_wdata,
    output logic              rsp_valid,
    input  logic              rsp_ready,
    output logic [DATA_W-1:0] rsp_rdata,
    output logic              rsp_err,
    output logic              reg_enable,
    output logic              reg_rw,
    output logic [ADDR_W-1:0] reg_addr,
    output logic [DATA_W-1:0] reg_wdata,
    input  logic [DATA_W-1:0] reg_rdata,
    output logic              busy
);
    localparam int CMD_W = 1 + ADDR_W + DATA_W;
    state_e state_q, state_d;
    logic [ADDR_W-1:0] reg_addr_q, reg_addr_d;
    logic [DATA_W-1:0] reg_wdata_q, reg_wdata_d, rsp_rdata_q, rsp_rdata_d;
    logic reg_rw_q, reg_rw_d, cmd_rw_q, cmd_rw_d;
    logic [CMD_W-1:0] head;
    logic full, empty, pop;
    reg_cmd_fifo #(.WIDTH(CMD_W), .DEPTH(FIFO_DEPTH)) u_fifo (
        .Clk     (Clk),
        .nReset  (nReset),
        .push_i  (cmd_valid),
        .pop_i   (pop),
        .wdata_i ({cmd_rw, cmd_addr, cmd_wdata}),
        .rdata_o (head),
        .full_o  (full),
        .empty_o (empty)
    );
`ifdef READBACK_VERIFY_EN
    logic rsp_err_q, rsp_err_d;
    assign rsp_err = rsp_err_q;
    always_ff @(posedge Clk) rsp_err_q <= nReset ? rsp_err_d : 1'b0;
`else
    assign rsp_err = 1'b0;
`endif
    assign cmd_ready  = !full;
    assign rsp_valid  = state_q == RESP;
    assign rsp_rdata  = rsp_rdata_q;
    assign reg_enable = (state_q == STROBE) || (state_q == VSTROBE);
    assign reg_rw     = reg_rw_q;
    assign reg_addr   = reg_addr_q;
    assign reg_wdata  = reg_wdata_q;
    assign busy       = (state_q != IDLE) || !empty;
    always_ff @(posedge Clk) begin
        if (!nReset) begin
            state_q     <= IDLE;
            reg_addr_q  <= '0;
            reg_wdata_q <= '0;
            rsp_rdata_q <= '0;
            reg_rw_q    <= 1'b0;
            cmd_rw_q    <= 1'b0;
        end else begin
            state_q     <= state_d;
            reg_addr_q  <= reg_addr_d;
            reg_wdata_q <= reg_wdata_d;
            rsp_rdata_q <= rsp_rdata_d;
            reg_rw_q    <= reg_rw_d;
            cmd_rw_q    <= cmd_rw_d;
        end
    end
    always_comb begin
        state_d     = state_q;
        reg_addr_d  = reg_addr_q;
        reg_wdata_d = reg_wdata_q;
        rsp_rdata_d = rsp_rdata_q;
        reg_rw_d    = reg_rw_q;
        cmd_rw_d    = cmd_rw_q;
        pop         = 1'b0;
`ifdef READBACK_VERIFY_EN
        rsp_err_d   = rsp_err_q;
`endif
        case (state_q)
            IDLE: begin
                pop     = !empty;
                state_d = empty ? IDLE : SETUP;
            end
            SETUP: state_d = STROBE;
`ifdef READBACK_VERIFY_EN
            // Writes turn around into a read of the same address before capturing.
            STROBE: begin
                state_d  = cmd_rw_q ? VSETUP : CAPTURE;
                reg_rw_d = 1'b0;
            end
            VSETUP:  state_d = VSTROBE;
            VSTROBE: state_d = CAPTURE;
            CAPTURE: begin
                state_d     = RESP;
                rsp_rdata_d = reg_rdata;
                rsp_err_d   = cmd_rw_q && (reg_rdata != reg_wdata_q);
            end
`else
            STROBE: state_d = CAPTURE;
            CAPTURE: begin
                state_d     = RESP;
                rsp_rdata_d = cmd_rw_q ? '0 : reg_rdata;
            end
`endif
            RESP: begin
                pop     = rsp_ready && !empty;
                state_d = rsp_ready ? (empty ? IDLE : SETUP) : RESP;
            end
            default: state_d = IDLE;
        endcase
        if (pop) begin
            {reg_rw_d, reg_addr_d, reg_wdata_d} = head;
            cmd_rw_d = head[CMD_W-1];
        end
    end
endmodule

// File: tb/tb_reg_access_sequencer.sv
// tb_reg_access_sequencer: drives reg_access_sequencer against a negedge register-set model with a response scoreboard.
// Address 2 of the model has bit0 stuck at 0.
module tb_reg_access_sequencer;
    import reg_seq_pkg::*;
`ifdef READBACK_VERIFY_EN
    localparam bit VERIFY = 1'b1;
`else
    localparam bit VERIFY = 1'b0;
`endif
    localparam int WR_LAT = VERIFY ? 6 : 4;
    localparam int RD_LAT = 4;
    logic Clk = 1'b0, nReset = 1'b0;
    logic cmd_valid = 1'b0, cmd_rw = 1'b0, rsp_ready = 1'b0;
    logic [2:0] cmd_addr = '0;
    logic [7:0] cmd_wdata = '0;
    logic cmd_ready, rsp_valid, rsp_err, reg_enable, reg_rw, busy;
    logic [7:0] rsp_rdata, reg_wdata;
    logic [2:0] reg_addr;
    logic [7:0] model_rdata = '0;
    logic [7:0] regs [8] = '{default: '0};
    logic [7:0] shadow [8];
    logic [8:0] exp_q [$];
    logic [8:0] got_q [$];
    int rd_idx = 0, n_cmp = 0, n_bad = 0;
    reg_access_sequencer u_dut (
        .Clk(Clk), .nReset(nReset),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_rw(cmd_rw), .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err),
        .reg_enable(reg_enable), .reg_rw(reg_rw), .reg_addr(reg_addr), .reg_wdata(reg_wdata), .reg_rdata(model_rdata),
        .busy(busy)
    );
    always #5 Clk = ~Clk;
    function automatic logic [7:0] stored(input logic [2:0] a, input logic [7:0] d);
        return (a == 3'd2) ? (d & 8'hFE) : d;
    endfunction
    always @(negedge Clk) begin
        if (reg_enable) begin
            if (reg_rw) regs[reg_addr] <= stored(reg_addr, reg_wdata);
            else model_rdata <= regs[reg_addr];
        end
    end
    always @(posedge Clk) begin
        if (nReset && rsp_valid && rsp_ready) got_q.push_back({rsp_err, rsp_rdata});
    end
    task automatic step();
        @(posedge Clk);
        #1;
    endtask
    task automatic push_cmd(input logic rw, input logic [2:0] a, input logic [7:0] d);
        logic [7:0] st;
        int t;
        st = stored(a, d);
        cmd_valid = 1'b1; cmd_rw = rw; cmd_addr = a; cmd_wdata = d;
        t = 0;
        while (!cmd_ready && t < 50) begin step(); t++; end
        n_cmp++;
        if (cmd_ready !== 1'b1) begin n_bad++; $display("FAIL push_timeout: cmd_ready=%b required 1", cmd_ready); end
        step();
        cmd_valid = 1'b0;
        if (rw) begin
            shadow[a] = st;
            exp_q.push_back({VERIFY && (st != d), VERIFY ? st : 8'h00});
        end else exp_q.push_back({1'b0, shadow[a]});
    endtask
    task automatic test_reset();
        for (int i = 0; i < 8; i++) shadow[i] = '0;
        repeat (3) step();
        n_cmp++;
        if ({cmd_ready, rsp_valid, rsp_rdata, rsp_err, reg_enable, reg_rw, reg_addr, reg_wdata, busy} !== {1'b1, 24'h0}) begin
            n_bad++;
            $display("FAIL reset_outputs: got %h required %h",
                {cmd_ready, rsp_valid, rsp_rdata, rsp_err, reg_enable, reg_rw, reg_addr, reg_wdata, busy}, {1'b1, 24'h0});
        end
        nReset = 1'b1;
        step();
    endtask
    task automatic test_write_read();
        int lat;
        rsp_ready = 1'b1;
        for (int j = 0; j < 2; j++) begin
            lat = (j == 0) ? WR_LAT : RD_LAT;
            push_cmd(j == 0, 3'd5, 8'hA5);
            for (int k = 1; k <= lat; k++) begin
                step();
                if (k == lat - 1) begin
                    n_cmp++;
                    if (rsp_valid !== 1'b0) begin n_bad++; $display("FAIL early_rsp[%0d]: rsp_valid=%b required 0 at E+%0d", j, rsp_valid, k); end
                end
            end
            n_cmp++;
            if (rsp_valid !== 1'b1) begin n_bad++; $display("FAIL latency[%0d]: rsp_valid=%b required 1 at E+%0d", j, rsp_valid, lat); end
            step();
            n_cmp++;
            if (got_q.size() <= rd_idx) begin n_bad++; $display("FAIL rsp_missing[%0d]: no response, required %h", j, exp_q[0]); end
            else begin
                if (got_q[rd_idx] !== exp_q[0]) begin n_bad++; $display("FAIL wr_rd_rsp[%0d]: got %h required %h", j, got_q[rd_idx], exp_q[0]); end
                rd_idx++;
            end
            void'(exp_q.pop_front());
        end
    endtask
    task automatic test_fill();
        rsp_ready = 1'b0;
        for (int j = 0; j < 5; j++) begin
            n_cmp++;
            if (cmd_ready !== 1'b1) begin n_bad++; $display("FAIL ready_before_push[%0d]: cmd_ready=%b required 1", j, cmd_ready); end
            push_cmd(j % 2 == 0, 3'(j - (j % 2)), 8'(j * 17 + 1));
        end
        n_cmp++;
        if (cmd_ready !== 1'b0) begin n_bad++; $display("FAIL ready_full: cmd_ready=%b required 0", cmd_ready); end
    endtask
    task automatic test_backpressure();
        int t;
        t = 0;
        while (!rsp_valid && t < 20) begin step(); t++; end
        for (int k = 0; k < 10; k++) begin
            n_cmp++;
            if ({rsp_valid, rsp_err, rsp_rdata, reg_enable, cmd_ready} !== {1'b1, exp_q[0], 1'b0, 1'b0}) begin
                n_bad++;
                $display("FAIL stall[%0d]: got %h required %h", k,
                    {rsp_valid, rsp_err, rsp_rdata, reg_enable, cmd_ready}, {1'b1, exp_q[0], 1'b0, 1'b0});
            end
            step();
        end
        rsp_ready = 1'b1;
        t = 0;
        while (got_q.size() < rd_idx + exp_q.size() && t < 200) begin step(); t++; end
        while (exp_q.size() > 0 && rd_idx < got_q.size()) begin
            n_cmp++;
            if (got_q[rd_idx] !== exp_q[0]) begin n_bad++; $display("FAIL drain[%0d]: got %h required %h", rd_idx, got_q[rd_idx], exp_q[0]); end
            rd_idx++;
            void'(exp_q.pop_front());
        end
        n_cmp++;
        if (exp_q.size() !== 0) begin n_bad++; $display("FAIL drain_missing: %0d responses missing, required 0", exp_q.size()); exp_q.delete(); end
    endtask
    task automatic test_reset_strobe();
        int t;
        rsp_ready = 1'b1;
        cmd_valid = 1'b1; cmd_rw = 1'b1; cmd_addr = 3'd1; cmd_wdata = 8'h3C;
        step();
        cmd_valid = 1'b0;
        t = 0;
        while (!reg_enable && t < 10) begin step(); t++; end
        n_cmp++;
        if (reg_enable !== 1'b1) begin n_bad++; $display("FAIL strobe_seen: reg_enable=%b required 1", reg_enable); end
        shadow[1] = stored(3'd1, 8'h3C);
        nReset = 1'b0;
        step();
        n_cmp++;
        if ({cmd_ready, rsp_valid, rsp_rdata, rsp_err, reg_enable, reg_rw, reg_addr, reg_wdata, busy} !== {1'b1, 24'h0}) begin
            n_bad++;
            $display("FAIL reset_in_strobe: got %h required %h",
                {cmd_ready, rsp_valid, rsp_rdata, rsp_err, reg_enable, reg_rw, reg_addr, reg_wdata, busy}, {1'b1, 24'h0});
        end
        nReset = 1'b1;
        repeat (10) step();
        n_cmp++;
        if (got_q.size() !== rd_idx) begin n_bad++; $display("FAIL dropped_rsp: responses=%0d required %0d", got_q.size(), rd_idx); end
    endtask
    task automatic test_verify();
        rsp_ready = 1'b1;
        push_cmd(1'b1, 3'd2, 8'h01);
        repeat (WR_LAT) step();
        n_cmp++;
        if (rsp_valid !== 1'b1) begin n_bad++; $display("FAIL verify_latency: rsp_valid=%b required 1 at E+%0d", rsp_valid, WR_LAT); end
        step();
        n_cmp++;
        if (got_q.size() <= rd_idx) begin n_bad++; $display("FAIL verify_missing: no response, required %h", exp_q[0]); end
        else begin
            if (got_q[rd_idx] !== exp_q[0]) begin n_bad++; $display("FAIL verify_rsp: got %h required %h", got_q[rd_idx], exp_q[0]); end
            rd_idx++;
        end
        void'(exp_q.pop_front());
    endtask
    task automatic test_wrap();
        int t;
        rsp_ready = 1'b0;
        for (int j = 0; j < 4; j++) push_cmd(1'($urandom_range(0, 1)), 3'($urandom_range(0, 7)), 8'($urandom));
        t = 0;
        while (!rsp_valid && t < 20) begin step(); t++; end
        n_cmp++;
        if (u_dut.u_fifo.count_q !== 3'd3) begin n_bad++; $display("FAIL count_before: got %0d required 3", u_dut.u_fifo.count_q); end
        rsp_ready = 1'b1;
        push_cmd(1'b1, 3'd6, 8'h5A);
        n_cmp++;
        if (u_dut.u_fifo.count_q !== 3'd3) begin n_bad++; $display("FAIL count_push_pop: got %0d required 3", u_dut.u_fifo.count_q); end
        for (int j = 0; j < 7; j++) push_cmd(1'($urandom_range(0, 1)), 3'($urandom_range(0, 7)), 8'($urandom));
        t = 0;
        while (got_q.size() < rd_idx + exp_q.size() && t < 300) begin step(); t++; end
        while (exp_q.size() > 0 && rd_idx < got_q.size()) begin
            n_cmp++;
            if (got_q[rd_idx] !== exp_q[0]) begin n_bad++; $display("FAIL wrap[%0d]: got %h required %h", rd_idx, got_q[rd_idx], exp_q[0]); end
            rd_idx++;
            void'(exp_q.pop_front());
        end
        n_cmp++;
        if (exp_q.size() !== 0) begin n_bad++; $display("FAIL wrap_missing: %0d responses missing, required 0", exp_q.size()); exp_q.delete(); end
    endtask
    initial begin
        test_reset();
        test_write_read();
        test_fill();
        test_backpressure();
        test_reset_strobe();
        test_verify();
        test_wrap();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
